fml_rr_arb4: RTL and testbench
==============================

// Module: fml_rr_arb4
// PURPOSE
//  Four-master FML arbiter for the 16-bit SDRAM port. Shares one FML slave (the SDRAM controller)
//  between masters m0..m3 using round-robin, with an optional fixed high priority for m0.
//  Tracks 4-beat write bursts so write data stays with the acked master while the grant moves on.
//  Sits between the FML masters (CPU cache, VGA fetch, DMA and similar) and the SDRAM controller.
// PARAMETERS
//  fml_depth  25  FML address width (bits)
//  burst_len  4   beats per FML burst; write data is held for burst_len cycles starting at ack
//  hi_prio0   1   1: m0 preempts the round-robin at each arbitration point; 0: m0 is a plain RR peer
// PORTS
//  sys_clk      in   1          system clock; all state on its rising edge
//  sys_rst_n    in   1          asynchronous active-low reset
//  mN_adr       in   fml_depth  master N address (N=0..3)
//  mN_stb       in   1          master N request; held until mN_ack
//  mN_we        in   1          master N write enable
//  mN_sel       in   2          master N byte enables (beat 0)
//  mN_di        in   16         master N write data
//  mN_ack       out  1          master N ack; 1-cycle pulse
//  mN_do        out  16         read data; s_di broadcast to all masters
//  s_adr/s_stb/s_we/s_sel  out  fml_depth/1/1/2  muxed from the granted master
//  s_ack        in   1          slave ack; first data beat occurs in the ack cycle
//  s_di         in   16         slave read data
//  s_do         out  16         write data to the slave
//  grant        out  2          current grant (debug and perf counters)
// BEHAVIOUR
//  - Reset (async, immediate): grant=0, wmaster=0, burst_cnt=0. Outputs follow m0; all mN_ack=0.
//  - Request path is combinational: s_adr/stb/we/sel = m[grant]. mN_ack = (grant==N) & s_ack.
//  - Arbitration point: a cycle with ~m[grant]_stb | s_ack. Outside it, next_grant=grant.
//  - At an arbitration point (next_grant registered into grant):
//    * hi_prio0=1, m0_stb=1, grant!=0 -> next_grant=0.
//    * Otherwise pick the first requester in circular order grant+1, grant+2, grant+3, grant.
//    * When grant=0 is completing with s_ack, m0 is excluded unless no other master requests.
//      This prevents m0 from starving the others.
//    * No requester -> hold grant; s_stb=0.
//  - The grant may change the cycle after ack, so back-to-back transactions from different masters
//    reach the slave with no bubble.
//  - Write burst: wr_start = s_we & s_ack.
//    * On wr_start: wmaster<=grant; burst_cnt<=burst_len-1.
//    * Otherwise, if burst_cnt!=0: burst_cnt decrements.
//    * s_do = (burst_cnt==0) ? m[grant]_di : m[wmaster]_di.
//    * Result: beat 0 comes from grant; beats 1..burst_len-1 come from wmaster.
//  - wr_start while burst_cnt!=0 (slave violation) reloads the counter and wmaster. No error flag.
//  - Read bursts need no tracking: s_di is broadcast, and masters qualify it with their own ack.
//  - burst_cnt width = $clog2(burst_len); burst_len must be >=2. Decrement never wraps below 0.
//  - Reset asserted mid-burst aborts the burst; the slave must be reset alongside this block.
// STRUCTURE
//  - fml_pkg: FML_DW=16, FML_SW=2, FML_NMASTERS=4, default burst length constant.
//  - Sub-module fml_rr_pick: 4-bit req + 2-bit last grant + exclude mask -> 2-bit winner and
//    any-request flag. Purely combinational, one instance.
//  - Top level holds the grant/wmaster/burst_cnt registers and the 4:1 muxes.
// TESTING
//  1. Reset: pull sys_rst_n low during a write burst (burst_cnt=2)
//     -> grant=0, burst_cnt=0, all acks 0 in the same cycle with no clock edge.
//  2. RR: m1,m2,m3 stb held high, hi_prio0=0, slave acks every 3rd cycle
//     -> ack order 1,2,3,1,2,3; one ack per slave ack.
//  3. Priority: hi_prio0=1, grant=3 in progress, m0 and m2 request
//     -> after m3 ack grant=0; after m0 ack grant=2, not 0.
//  4. Write hand-off: m1 write acked at cycle t, m2 read requested
//     -> s_do=m1_di for t..t+3, grant=2 at t+1, m2_ack on the next s_ack.
//  5. Idle: all stb low for 10 cycles after grant=2 -> grant stays 2, s_stb=0, no acks.
//  6. Fairness: hi_prio0=1, m0 requests continuously, m3 requests once
//     -> m3_ack within 2 slave transactions.

Source files
------------

// File: rtl/fml_rr_arb4_pkg.sv
// Shared constants, types and helpers for the four-master FML arbiter.
package fml_rr_arb4_pkg;

    localparam int unsigned FML_DW        = 16;
    localparam int unsigned FML_SW        = 2;
    localparam int unsigned FML_NMASTERS  = 4;
    localparam int unsigned FML_BURST_LEN = 4;
    localparam int unsigned FML_GW        = $clog2(FML_NMASTERS);

    typedef logic [FML_GW-1:0]       fml_gnt_t;
    typedef logic [FML_NMASTERS-1:0] fml_mask_t;

    // Master index 'step' positions after 'base' in circular order.
    function automatic fml_gnt_t fml_rr_next(fml_gnt_t base, int unsigned step);
        return fml_gnt_t'(32'(base) + step);
    endfunction

endpackage

// File: rtl/fml_rr_arb4_if.sv
// One FML link: request/write-data from the master side, ack/read-data back.
interface fml_rr_arb4_if #(
    parameter int unsigned AdrW = 25
) ();
    import fml_rr_arb4_pkg::*;

    logic [AdrW-1:0]   adr;
    logic              stb;
    logic              we;
    logic [FML_SW-1:0] sel;
    logic [FML_DW-1:0] wdat;
    logic [FML_DW-1:0] rdat;
    logic              ack;

    modport master (output adr, stb, we, sel, wdat, input ack, rdat);
    modport slave  (input adr, stb, we, sel, wdat, output ack, rdat);

endinterface

// File: rtl/fml_rr_arb4_pick.sv
// Combinational round-robin picker: first requester after last_i in circular order.
module fml_rr_arb4_pick
    import fml_rr_arb4_pkg::*;
(
    input  fml_mask_t req_i,
    input  fml_gnt_t  last_i,
    input  fml_mask_t excl_i,
    output fml_gnt_t  winner_o,
    output logic      any_o
);

    fml_gnt_t cand;

    // last_i itself is visited last, so a lone requester keeps the grant.
    always_comb begin
        winner_o = last_i;
        any_o    = 1'b0;
        cand     = last_i;
        for (int unsigned k = 1; k <= FML_NMASTERS; k++) begin
            cand = fml_rr_next(last_i, k);
            if (!any_o && req_i[cand] && !excl_i[cand]) begin
                winner_o = cand;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fml_rr_arb4.sv
// Four-master FML arbiter: round-robin grant with optional m0 priority, plus
// write-burst tracking so beats 1..N-1 stay with the acked master.
module fml_rr_arb4
    import fml_rr_arb4_pkg::*;
#(
    parameter int unsigned fml_depth = 25,
    parameter int unsigned burst_len = FML_BURST_LEN,
    parameter bit          hi_prio0  = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    fml_rr_arb4_if.slave      m0,
    fml_rr_arb4_if.slave      m1,
    fml_rr_arb4_if.slave      m2,
    fml_rr_arb4_if.slave      m3,
    fml_rr_arb4_if.master     s,
    output logic [FML_GW-1:0] grant
);

    localparam int unsigned     CntW    = $clog2(burst_len);
    localparam logic [CntW-1:0] CntLoad = CntW'(burst_len - 1);

    logic [fml_depth-1:0] m_adr [FML_NMASTERS];
    logic [FML_SW-1:0]    m_sel [FML_NMASTERS];
    logic [FML_DW-1:0]    m_di  [FML_NMASTERS];
    fml_mask_t            m_stb;
    fml_mask_t            m_we;

    fml_gnt_t        grant_d, grant_q;
    fml_gnt_t        wmaster_d, wmaster_q;
    logic [CntW-1:0] burst_cnt_d, burst_cnt_q;
    fml_gnt_t        winner;
    fml_mask_t       excl;
    logic            any_req;
    logic            arb_point;
    logic            wr_start;

    assign m_adr[0] = m0.adr;
    assign m_adr[1] = m1.adr;
    assign m_adr[2] = m2.adr;
    assign m_adr[3] = m3.adr;
    assign m_sel[0] = m0.sel;
    assign m_sel[1] = m1.sel;
    assign m_sel[2] = m2.sel;
    assign m_sel[3] = m3.sel;
    assign m_di[0]  = m0.wdat;
    assign m_di[1]  = m1.wdat;
    assign m_di[2]  = m2.wdat;
    assign m_di[3]  = m3.wdat;
    assign m_stb    = {m3.stb, m2.stb, m1.stb, m0.stb};
    assign m_we     = {m3.we, m2.we, m1.we, m0.we};

    assign s.adr  = m_adr[grant_q];
    assign s.stb  = m_stb[grant_q];
    assign s.we   = m_we[grant_q];
    assign s.sel  = m_sel[grant_q];
    // Beat 0 comes from the granted master, later beats from the burst owner.
    assign s.wdat = (burst_cnt_q == '0) ? m_di[grant_q] : m_di[wmaster_q];

    assign m0.ack  = (grant_q == fml_gnt_t'(0)) & s.ack;
    assign m1.ack  = (grant_q == fml_gnt_t'(1)) & s.ack;
    assign m2.ack  = (grant_q == fml_gnt_t'(2)) & s.ack;
    assign m3.ack  = (grant_q == fml_gnt_t'(3)) & s.ack;
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;
    assign m2.rdat = s.rdat;
    assign m3.rdat = s.rdat;
    assign grant   = grant_q;

    assign arb_point = ~m_stb[grant_q] | s.ack;
    assign wr_start  = m_we[grant_q] & s.ack;

    // m0 finishing a transaction yields to anyone else waiting.
    always_comb begin
        excl    = '0;
        excl[0] = (grant_q == '0) & s.ack & (|m_stb[FML_NMASTERS-1:1]);
    end

    fml_rr_arb4_pick u_pick (
        .req_i   (m_stb),
        .last_i  (grant_q),
        .excl_i  (excl),
        .winner_o(winner),
        .any_o   (any_req)
    );

    always_comb begin
        grant_d = grant_q;
        if (arb_point) begin
            if (hi_prio0 && m_stb[0] && (grant_q != '0)) begin
                grant_d = '0;
            end else if (any_req) begin
                grant_d = winner;
            end
        end
    end

    // A new write ack always reloads, even mid-burst.
    always_comb begin
        wmaster_d   = wmaster_q;
        burst_cnt_d = burst_cnt_q;
        if (wr_start) begin
            wmaster_d   = grant_q;
            burst_cnt_d = CntLoad;
        end else if (burst_cnt_q != '0) begin
            burst_cnt_d = burst_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_q     <= '0;
            wmaster_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            grant_q     <= grant_d;
            wmaster_q   <= wmaster_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fml_rr_arb4.sv
// Bench for fml_rr_arb4: two instances (m0 priority on/off) against a cycle model.
module tb_fml_rr_arb4;

    localparam int unsigned AW = 25;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] m_adr [2][4];
    logic          m_stb [2][4];
    logic          m_we  [2][4];
    logic [1:0]    m_sel [2][4];
    logic [15:0]   m_di  [2][4];
    logic          ack_o [2][4];
    logic [15:0]   do_o  [2][4];
    logic [AW-1:0] s_adr [2];
    logic          s_stb [2];
    logic          s_we  [2];
    logic [1:0]    s_sel [2];
    logic [15:0]   s_do  [2];
    logic          s_ack [2];
    logic [15:0]   s_di  [2];
    logic [1:0]    grant [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        fml_rr_arb4_if #(.AdrW(AW)) mif [4] ();
        fml_rr_arb4_if #(.AdrW(AW)) sif ();
        for (genvar n = 0; n < 4; n++) begin : g_m
            assign mif[n].adr  = m_adr[k][n];
            assign mif[n].stb  = m_stb[k][n];
            assign mif[n].we   = m_we[k][n];
            assign mif[n].sel  = m_sel[k][n];
            assign mif[n].wdat = m_di[k][n];
            assign ack_o[k][n] = mif[n].ack;
            assign do_o[k][n]  = mif[n].rdat;
        end
        assign s_adr[k]  = sif.adr;
        assign s_stb[k]  = sif.stb;
        assign s_we[k]   = sif.we;
        assign s_sel[k]  = sif.sel;
        assign s_do[k]   = sif.wdat;
        assign sif.ack   = s_ack[k];
        assign sif.rdat  = s_di[k];

        fml_rr_arb4 #(
            .fml_depth(AW),
            .burst_len(4),
            .hi_prio0 (k == 0)
        ) u_dut (
            .sys_clk  (clk),
            .sys_rst_n(rst_n),
            .m0       (mif[0]),
            .m1       (mif[1]),
            .m2       (mif[2]),
            .m3       (mif[3]),
            .s        (sif),
            .grant    (grant[k])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mg [2];
    int wm [2];
    int wr_until [2];

    task automatic chk(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    // Grant after a cycle, straight from the arbitration rules.
    function automatic int model_pick(int g, bit hi, bit [3:0] st, bit ack);
        int c;
        if (st[g] && !ack) return g;
        if (hi && st[0] && g != 0) return 0;
        for (int i = 1; i <= 4; i++) begin
            c = (g + i) % 4;
            if (st[c] && !(c == 0 && g == 0 && ack && st[3:1] != 3'b000)) return c;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mg[k] = 0;
            wm[k] = 0;
            wr_until[k] = 0;
        end
    endtask

    task automatic model_step();
        bit [3:0] st;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) continue;
            for (int n = 0; n < 4; n++) st[n] = m_stb[k][n];
            if (m_we[k][mg[k]] && s_ack[k]) begin
                wm[k] = mg[k];
                wr_until[k] = cyc + 4;
            end
            mg[k] = model_pick(mg[k], k == 0, st, s_ack[k]);
        end
        cyc++;
    endtask

    task automatic compare_all();
        int g;
        logic [15:0] e_do;
        logic [3:0] ea, aa;
        for (int k = 0; k < 2; k++) begin
            g = mg[k];
            e_do = (cyc < wr_until[k]) ? m_di[k][wm[k]] : m_di[k][g];
            for (int n = 0; n < 4; n++) begin
                ea[n] = (n == g) && s_ack[k];
                aa[n] = ack_o[k][n];
                chk(k, "m_do", 32'(do_o[k][n]), 32'(s_di[k]));
            end
            chk(k, "grant", 32'(grant[k]), 32'(g));
            chk(k, "acks", 32'(aa), 32'(ea));
            chk(k, "s_stb", 32'(s_stb[k]), 32'(m_stb[k][g]));
            chk(k, "s_we", 32'(s_we[k]), 32'(m_we[k][g]));
            chk(k, "s_adr", 32'(s_adr[k]), 32'(m_adr[k][g]));
            chk(k, "s_sel", 32'(s_sel[k]), 32'(m_sel[k][g]));
            chk(k, "s_do", 32'(s_do[k]), 32'(e_do));
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 2; k++) begin
            s_di[k] = 16'($urandom);
            for (int n = 0; n < 4; n++) m_di[k][n] = 16'($urandom);
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
        rand_data();
    endtask

    task automatic all_idle();
        for (int k = 0; k < 2; k++) begin
            s_ack[k] = 1'b0;
            for (int n = 0; n < 4; n++) begin
                m_stb[k][n] = 1'b0;
                m_we[k][n]  = 1'b0;
                m_sel[k][n] = 2'b11;
                m_adr[k][n] = AW'(n * 16);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        all_idle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_stb(input int n, input logic v, input logic we);
        for (int k = 0; k < 2; k++) begin
            m_stb[k][n] = v;
            m_we[k][n]  = we;
        end
    endtask

    task automatic set_ack(input logic v);
        for (int k = 0; k < 2; k++) s_ack[k] = v;
    endtask

    int exp_rr [6] = '{1, 2, 3, 1, 2, 3};
    int order [$];
    int ackm [2];
    int tx;
    bit seen;

    initial begin
        rst_n = 1'b0;
        all_idle();
        rand_data();
        model_reset();
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_grant", 32'(grant[k]), 0);
            chk(k, "rst_s_stb", 32'(s_stb[k]), 0);
        end
        cycle();
        rst_n = 1'b1;

        // Round robin with m0 idle: acks every third cycle.
        do_reset();
        for (int n = 1; n < 4; n++) set_stb(n, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            set_ack(i % 3 == 2);
            #1;
            for (int n = 0; n < 4; n++) if (ack_o[1][n]) order.push_back(n);
            cycle();
        end
        chk(1, "rr_count", 32'(order.size()), 6);
        for (int i = 0; i < 6; i++)
            chk(1, "rr_order", (i < order.size()) ? 32'(order[i]) : 32'hffff_ffff,
                32'(exp_rr[i]));

        // Priority: m3 in progress, then m0 and m2 request.
        do_reset();
        set_stb(3, 1'b1, 1'b0);
        cycle();
        set_stb(0, 1'b1, 1'b0);
        set_stb(2, 1'b1, 1'b0);
        #1;
        chk(0, "prio_g3", 32'(grant[0]), 3);
        cycle();
        set_ack(1'b1);
        cycle();
        set_stb(3, 1'b0, 1'b0);
        #1;
        chk(0, "prio_g0", 32'(grant[0]), 0);
        cycle();
        set_stb(0, 1'b0, 1'b0);
        set_ack(1'b0);
        #1;
        chk(0, "prio_g2", 32'(grant[0]), 2);
        cycle();

        // Write hand-off: m1 write acked at t, m2 read waits.
        do_reset();
        set_stb(1, 1'b1, 1'b1);
        cycle();
        set_ack(1'b1);
        set_stb(2, 1'b1, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "wr_beat0", 32'(s_do[k]), 32'(m_di[k][1]));
            chk(k, "wr_ack1", 32'(ack_o[k][1]), 1);
        end
        cycle();
        set_stb(1, 1'b0, 1'b0);
        set_ack(1'b0);
        for (int b = 1; b < 4; b++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                chk(k, "wr_beat", 32'(s_do[k]), 32'(m_di[k][1]));
                if (b == 1) chk(k, "wr_grant2", 32'(grant[k]), 2);
            end
            cycle();
        end
        set_ack(1'b1);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "wr_after", 32'(s_do[k]), 32'(m_di[k][2]));
            chk(k, "rd_ack2", 32'(ack_o[k][2]), 1);
        end
        cycle();
        set_stb(2, 1'b0, 1'b0);
        set_ack(1'b0);

        // Idle: grant holds at 2.
        for (int i = 0; i < 10; i++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                chk(k, "idle_grant", 32'(grant[k]), 2);
                chk(k, "idle_stb", 32'(s_stb[k]), 0);
            end
            cycle();
        end

        // Fairness: m0 continuous, m3 once.
        set_stb(0, 1'b1, 1'b0);
        set_stb(3, 1'b1, 1'b0);
        tx = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            for (int k = 0; k < 2; k++) s_ack[k] = m_stb[k][mg[k]];
            #1;
            if (s_ack[0]) tx++;
            if (ack_o[0][3]) seen = 1'b1;
            cycle();
            if (seen) set_stb(3, 1'b0, 1'b0);
        end
        chk(0, "fair_seen", 32'(seen), 1);
        chk(0, "fair_tx", 32'(tx <= 2), 1);
        set_stb(0, 1'b0, 1'b0);
        set_ack(1'b0);

        // Async reset in the middle of a write burst.
        do_reset();
        set_stb(2, 1'b1, 1'b1);
        cycle();
        set_ack(1'b1);
        set_stb(1, 1'b1, 1'b0);
        cycle();
        set_stb(2, 1'b0, 1'b0);
        set_ack(1'b0);
        cycle();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "burst_owner", 32'(s_do[k]), 32'(m_di[k][2]));
            chk(k, "burst_grant", 32'(grant[k]), 1);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "arst_grant", 32'(grant[k]), 0);
            chk(k, "arst_do", 32'(s_do[k]), 32'(m_di[k][0]));
            for (int n = 0; n < 4; n++) chk(k, "arst_ack", 32'(ack_o[k][n]), 0);
        end
        cycle();
        rst_n = 1'b1;
        all_idle();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            for (int k = 0; k < 2; k++) begin
                for (int n = 0; n < 4; n++) begin
                    if (!m_stb[k][n] && $urandom_range(2) == 0) begin
                        m_stb[k][n] = 1'b1;
                        m_we[k][n]  = 1'($urandom);
                        m_sel[k][n] = 2'($urandom);
                        m_adr[k][n] = AW'($urandom);
                    end
                end
                s_ack[k] = m_stb[k][mg[k]] &&
                           ((cyc >= wr_until[k] && $urandom_range(1) == 1) ||
                            $urandom_range(31) == 0);
                ackm[k] = s_ack[k] ? mg[k] : -1;
            end
            cycle();
            for (int k = 0; k < 2; k++) if (ackm[k] >= 0) m_stb[k][ackm[k]] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
